cd_drive_link: RTL

// - Drive-side model of the CD mechanism serial link, upstream of the CD block: feeds SH1 RXD0 (CDATA), consumes TXD0 (HDATA).
// - SH1 owns the clock (COMCLK from SCK0O); this block frames the exchange with COMSYNC_N/COMREQ_N.
// - Each frame: 13 status bytes out, 13 command bytes in, full duplex, LSB first; command checksum is verified.

---
 rtl/cd_drive_link_if.sv | 30 +++
 rtl/cd_drive_link.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cd_drive_link_if.sv
// Signal bundle between the SH1 serial port / host side and the CD drive link.
// The drive link itself connects through the slave modport.
interface cd_drive_link_if;
    logic       COMCLK;
    logic       HDATA;
    logic       CDATA;
    logic       COMREQ_N;
    logic       COMSYNC_N;
    logic       STAT_WR;
    logic [7:0] STAT_D;
    logic       STAT_GO;
    logic       BUSY;
    logic [7:0] CMD_D;
    logic [3:0] CMD_IDX;
    logic       CMD_VLD;
    logic       CMD_DONE;
    logic       CMD_ERR;

    modport slave (
        input  COMCLK, HDATA, STAT_WR, STAT_D, STAT_GO,
        output CDATA, COMREQ_N, COMSYNC_N, BUSY,
        output CMD_D, CMD_IDX, CMD_VLD, CMD_DONE, CMD_ERR
    );

    modport master (
        output COMCLK, HDATA, STAT_WR, STAT_D, STAT_GO,
        input  CDATA, COMREQ_N, COMSYNC_N, BUSY,
        input  CMD_D, CMD_IDX, CMD_VLD, CMD_DONE, CMD_ERR
    );
endinterface

// File: rtl/cd_drive_link.sv
// Drive-side CD mechanism serial link: 13-byte status/command frames, LSB first.
// Define CD_LINK_CHKGEN_EN to generate status byte 11 as a checksum at frame start.
module cd_drive_link #(
    parameter int FRAME_BYTES = 13,
    parameter int GAP_CYC     = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CE,
    cd_drive_link_if.slave link
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SYNC  = 3'd1;
    localparam logic [2:0] REQ   = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam int GW = $clog2(GAP_CYC);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [3:0]    LAST  = 4'(FRAME_BYTES - 1);
    localparam logic [3:0]    CHK   = 4'(FRAME_BYTES - 2);
    localparam logic [GW-1:0] GLAST = GW'(GAP_CYC - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    logic [2:0]    state;
    logic [7:0]    stat [FRAME_BYTES];
    logic [7:0]    tx   [FRAME_BYTES];
    logic [3:0]    wp;
    logic          pend;
    logic          ck_s1, ck_s2, ck_d;
    logic          hd_s1, hd_s2;
    logic [3:0]    byte_cnt;
    logic [2:0]    bcnt;
    logic [6:0]    rxsr;
    logic [GW-1:0] gcnt;
    logic [TW-1:0] tcnt;
    logic [7:0]    sum;
    logic          err;
    logic          cdata;
    logic [7:0]    cmd_d;
    logic [3:0]    cmd_idx;
    logic          cmd_vld;

    logic       rise, fall;
    logic [7:0] cur;
    logic [7:0] rxb;
    logic [3:0] nxt;

    assign rise = ck_s2 & ~ck_d;
    assign fall = ~ck_s2 & ck_d;
    assign cur  = tx[byte_cnt];
    assign rxb  = {hd_s2, rxsr};
    assign nxt  = byte_cnt + 4'd1;

`ifdef CD_LINK_CHKGEN_EN
    logic [7:0] ssum;
    always_comb begin
        ssum = '0;
        for (int i = 0; i < FRAME_BYTES - 2; i++) ssum = ssum + stat[i];
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            wp       <= '0;
            pend     <= 1'b0;
            ck_s1    <= 1'b1;
            ck_s2    <= 1'b1;
            ck_d     <= 1'b1;
            hd_s1    <= 1'b1;
            hd_s2    <= 1'b1;
            byte_cnt <= '0;
            bcnt     <= '0;
            rxsr     <= '0;
            gcnt     <= '0;
            tcnt     <= '0;
            sum      <= '0;
            err      <= 1'b0;
            cdata    <= 1'b1;
            cmd_d    <= '0;
            cmd_idx  <= '0;
            cmd_vld  <= 1'b0;
            for (int i = 0; i < FRAME_BYTES; i++) begin
                stat[i] <= '0;
                tx[i]   <= '0;
            end
        end else if (CE) begin
            ck_s1   <= link.COMCLK;
            ck_s2   <= ck_s1;
            ck_d    <= ck_s2;
            hd_s1   <= link.HDATA;
            hd_s2   <= hd_s1;
            cmd_vld <= 1'b0;

            if (link.STAT_WR) begin
                stat[wp] <= link.STAT_D;
                if (wp != LAST) wp <= wp + 4'd1;
            end
            if (link.STAT_GO) wp <= '0;
            if (link.STAT_GO && state != IDLE) pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (link.STAT_GO) state <= SYNC;
                end
                SYNC: begin
                    // Shadow copy lets the host refill the buffer mid-frame
                    for (int i = 0; i < FRAME_BYTES; i++) tx[i] <= stat[i];
`ifdef CD_LINK_CHKGEN_EN
                    tx[CHK] <= ~ssum;
`endif
                    byte_cnt <= '0;
                    bcnt     <= '0;
                    tcnt     <= '0;
                    sum      <= '0;
                    err      <= 1'b0;
                    cdata    <= stat[0][0];
                    state    <= REQ;
                end
                REQ: begin
                    if (rise || fall) begin
                        tcnt <= '0;
                        if (fall) state <= SHIFT;
                    end else if (tcnt == TLAST) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        tcnt <= '0;
                        rxsr <= {hd_s2, rxsr[6:1]};
                        bcnt <= bcnt + 3'd1;
                        if (bcnt == 3'd7) begin
                            cmd_d   <= rxb;
                            cmd_idx <= byte_cnt;
                            cmd_vld <= 1'b1;
                            if (byte_cnt < CHK) sum <= sum + rxb;
                            if (byte_cnt == CHK && rxb != ~sum) err <= 1'b1;
                            gcnt  <= '0;
                            state <= GAP;
                        end
                    end else if (fall) begin
                        tcnt  <= '0;
                        cdata <= cur[bcnt];
                    end else if (tcnt == TLAST) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gcnt == GLAST) begin
                        if (byte_cnt == LAST) begin
                            state <= DONE;
                        end else begin
                            byte_cnt <= nxt;
                            cdata    <= tx[nxt][0];
                            bcnt     <= '0;
                            tcnt     <= '0;
                            state    <= REQ;
                        end
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                DONE: begin
                    // A GO seen during the frame starts the next one right away
                    pend  <= 1'b0;
                    state <= (pend || link.STAT_GO) ? SYNC : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign link.CDATA     = cdata;
    assign link.COMREQ_N  = !(state == REQ || state == SHIFT);
    assign link.COMSYNC_N = (state != SYNC);
    assign link.BUSY      = (state != IDLE);
    assign link.CMD_D     = cmd_d;
    assign link.CMD_IDX   = cmd_idx;
    assign link.CMD_VLD   = cmd_vld;
    assign link.CMD_DONE  = (state == DONE);
    assign link.CMD_ERR   = (state == DONE) && err;

endmodule
